// File: rtl/flag_stack_register_if.sv
// Flag stack register port bundle: ALU flag writes, push/pop/err_clr in; flags and stack status out.
// Latency: pure wiring, no state.
// Backpressure: none. Misuse is reported through the sticky err bit and is never stalled.
interface flag_stack_register_if #(
    parameter int NUM_FLAGS = 3,
    parameter int DEPTH     = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [NUM_FLAGS-1:0] flag_in;
    logic [NUM_FLAGS-1:0] flag_wen;
    logic                 push;
    logic                 pop;
    logic                 err_clr;
    logic [NUM_FLAGS-1:0] flag_out;
    logic [CW-1:0]        depth_cnt;
    logic                 full;
    logic                 empty;
    logic                 err;

    // Requester side: drives flag writes and stack commands.
    modport master (
        output flag_in, flag_wen, push, pop, err_clr,
        input  flag_out, depth_cnt, full, empty, err
    );

    // Register side: consumes commands and presents flags and status.
    modport slave (
        input  flag_in, flag_wen, push, pop, err_clr,
        output flag_out, depth_cnt, full, empty, err
    );
endinterface

// File: rtl/flag_stack_register.sv
// Condition-flag register with a save/restore stack and a sticky misuse error bit.
// Latency: flag writes land in one cycle. With FLAG_BYPASS_EN defined, flag_out forwards
// pending writes in the same cycle. Without it, flag_out shows only the registered value.
// Backpressure: none. Overflow, underflow and push+pop are dropped and set err until err_clr or rst.
module flag_stack_register #(
    parameter int NUM_FLAGS = 3,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    flag_stack_register_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NUM_FLAGS-1:0] cur;
    logic [NUM_FLAGS-1:0] eff;
    logic [NUM_FLAGS-1:0] stack [DEPTH];
    logic [CW-1:0]        depth_cnt;
    logic                 err;
    logic                 full;
    logic                 empty;
    logic                 push_acc;
    logic                 pop_acc;
    logic                 misuse;
    logic [AW-1:0]        push_idx;
    logic [AW-1:0]        pop_idx;

    // Status comes only from registered depth, so it never depends combinationally on push or pop.
    assign full  = (depth_cnt == CW'(DEPTH));
    assign empty = (depth_cnt == '0);

    // Command qualification. Push and pop together are treated as misuse and neither takes effect.
    assign push_acc = bus.push & ~bus.pop & ~full;
    assign pop_acc  = bus.pop & ~bus.push & ~empty;
    assign misuse   = (bus.push & bus.pop) | (bus.push & full) | (bus.pop & empty);

    // Only the low bits are needed to address entries. Both indices stay in range when their command is accepted.
    assign push_idx = AW'(depth_cnt);
    assign pop_idx  = AW'(depth_cnt - 1'b1);

    // Merged value: a pending per-bit write overrides the registered bit.
    always_comb begin
        eff = cur;
        for (int i = 0; i < NUM_FLAGS; i++) begin
            if (bus.flag_wen[i]) begin
                eff[i] = bus.flag_in[i];
            end
        end
    end

    // Current flags: an accepted pop restores from the stack and overrides any write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= '0;
        end else if (pop_acc) begin
            cur <= stack[pop_idx];
        end else begin
            cur <= eff;
        end
    end

    // Occupancy counter. It moves only on accepted commands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_cnt <= '0;
        end else if (push_acc) begin
            depth_cnt <= depth_cnt + 1'b1;
        end else if (pop_acc) begin
            depth_cnt <= depth_cnt - 1'b1;
        end
    end

    // Sticky error. A new misuse beats a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (misuse) begin
            err <= 1'b1;
        end else if (bus.err_clr) begin
            err <= 1'b0;
        end
    end

    // Stack storage has no reset. The push is gated off while rst is held so that cycle saves nothing.
    always_ff @(posedge clk) begin
        if (!rst && push_acc) begin
            stack[push_idx] <= eff;
        end
    end

    // Output flags. With forwarding, a restoring pop shows the pre-restore value for that cycle.
`ifdef FLAG_BYPASS_EN
    assign bus.flag_out = pop_acc ? cur : eff;
`else
    assign bus.flag_out = cur;
`endif

    assign bus.depth_cnt = depth_cnt;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.err       = err;

endmodule

// File: tb/tb_flag_stack_register.sv
// Directed bench for flag_stack_register with NUM_FLAGS=3 and DEPTH=2, checked through a scoreboard.
// The driver applies one vector per cycle and queues its expected outputs. The monitor checks them mid-cycle.
// The expected flag_out is selected according to FLAG_BYPASS_EN.
module tb_flag_stack_register;
    localparam int NF = 3;
    localparam int DP = 2;

    typedef struct packed {
        logic [2:0] cur;
        logic [2:0] byp;
        logic [1:0] dc;
        logic       er;
        logic [7:0] id;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb_q[$];
    logic chk_vld;
    int   n_vec;
    int   n_bad;
    int   vid;

    flag_stack_register_if #(.NUM_FLAGS(NF), .DEPTH(DP)) bus ();

    flag_stack_register #(.NUM_FLAGS(NF), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Applies one vector just after a rising edge and queues the outputs expected in that same cycle.
    task automatic step(input logic r, input logic [2:0] fin, input logic [2:0] wen,
                        input logic ps, input logic pp, input logic clr,
                        input logic [2:0] e_cur, input logic [2:0] e_byp,
                        input logic [1:0] e_dc, input logic e_er);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        bus.flag_in  = fin;
        bus.flag_wen = wen;
        bus.push     = ps;
        bus.pop      = pp;
        bus.err_clr  = clr;
        e.cur = e_cur;
        e.byp = e_byp;
        e.dc  = e_dc;
        e.er  = e_er;
        e.id  = 8'(vid);
        sb_q.push_back(e);
        vid++;
        chk_vld = 1'b1;
    endtask

    // Checks a queued expectation at each falling edge where a vector is pending.
    initial begin
        logic [2:0] want_fo;
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_vld) begin
                chk_vld = 1'b0;
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL scoreboard_empty: output presented with no expectation queued");
                end else begin
                    e = sb_q.pop_front();
`ifdef FLAG_BYPASS_EN
                    want_fo = e.byp;
`else
                    want_fo = e.cur;
`endif
                    if (bus.flag_out !== want_fo || bus.depth_cnt !== e.dc || bus.err !== e.er ||
                        bus.full !== (e.dc == 2'd2) || bus.empty !== (e.dc == 2'd0)) begin
                        n_bad++;
                        $display("FAIL vec%0d: got flag_out=%b depth=%0d full=%b empty=%b err=%b, want flag_out=%b depth=%0d full=%b empty=%b err=%b",
                                 e.id, bus.flag_out, bus.depth_cnt, bus.full, bus.empty, bus.err,
                                 want_fo, e.dc, (e.dc == 2'd2), (e.dc == 2'd0), e.er);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        vid = 0;
        chk_vld = 1'b0;
        rst = 1'b1;
        bus.flag_in = '0;
        bus.flag_wen = '0;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.err_clr = 1'b0;

        // Argument order: rst fin wen push pop clr | exp_cur exp_byp depth err
        step(1, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 0); // 0: reset state
        // Forwarding of a partial write
        step(0, 3'b101, 3'b001, 0, 0, 0, 3'b000, 3'b001, 0, 0); // 1
        // Save/restore
        step(0, 3'b011, 3'b010, 0, 0, 0, 3'b001, 3'b011, 0, 0); // 2: cur becomes 011
        step(0, 3'b100, 3'b100, 1, 0, 0, 3'b011, 3'b111, 0, 0); // 3: push eff=111
        step(0, 3'b000, 3'b111, 0, 0, 0, 3'b111, 3'b000, 1, 0); // 4: write 000
        step(0, 3'b000, 3'b000, 0, 1, 0, 3'b000, 3'b000, 1, 0); // 5: pop
        step(0, 3'b000, 3'b000, 0, 0, 0, 3'b111, 3'b111, 0, 0); // 6: restored
        // Overflow with DEPTH=2
        step(0, 3'b000, 3'b000, 1, 0, 0, 3'b111, 3'b111, 0, 0); // 7: push 111
        step(0, 3'b000, 3'b001, 1, 0, 0, 3'b111, 3'b110, 1, 0); // 8: push 110
        step(0, 3'b000, 3'b000, 1, 0, 0, 3'b110, 3'b110, 2, 0); // 9: overflow
        step(0, 3'b000, 3'b000, 0, 0, 0, 3'b110, 3'b110, 2, 1); // 10
        step(0, 3'b000, 3'b000, 0, 1, 0, 3'b110, 3'b110, 2, 1); // 11: pop
        step(0, 3'b000, 3'b000, 0, 1, 0, 3'b110, 3'b110, 1, 1); // 12: pop
        step(0, 3'b000, 3'b000, 0, 0, 0, 3'b111, 3'b111, 0, 1); // 13: stack[0] intact
        // Clear err, zero the flags, then underflow
        step(0, 3'b000, 3'b111, 0, 0, 1, 3'b111, 3'b000, 0, 1); // 14
        step(0, 3'b010, 3'b010, 0, 1, 0, 3'b000, 3'b010, 0, 0); // 15: underflow with write
        step(0, 3'b000, 3'b000, 0, 1, 1, 3'b010, 3'b010, 0, 1); // 16: clear plus underflow
        step(0, 3'b000, 3'b000, 0, 0, 1, 3'b010, 3'b010, 0, 1); // 17: clear alone
        // Pop beats write, then push and pop together
        step(0, 3'b101, 3'b111, 0, 0, 0, 3'b010, 3'b101, 0, 0); // 18: err cleared
        step(0, 3'b000, 3'b000, 1, 0, 0, 3'b101, 3'b101, 0, 0); // 19: push 101
        step(0, 3'b000, 3'b111, 0, 1, 0, 3'b101, 3'b101, 1, 0); // 20: pop with write
        step(0, 3'b000, 3'b000, 1, 0, 0, 3'b101, 3'b101, 0, 0); // 21: pop won, re-push
        step(0, 3'b000, 3'b000, 1, 1, 0, 3'b101, 3'b101, 1, 0); // 22: push+pop
        step(0, 3'b000, 3'b000, 1, 0, 0, 3'b101, 3'b101, 1, 1); // 23: depth held, push
        step(0, 3'b000, 3'b000, 0, 0, 0, 3'b101, 3'b101, 2, 1); // 24: full, err set
        // Mid-cycle async reset, with a push and a write that must be discarded
        step(1, 3'b111, 3'b111, 1, 0, 0, 3'b000, 3'b111, 0, 0); // 25
        step(0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 0); // 26

        @(posedge clk);
        @(posedge clk);
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
